qmult_seq: RTL and testbench

Sequential, parameterised successor to the combinational sign-magnitude Qm.n multiplier in the fixed-point template library. It computes one product per transaction with a shift-add datapath (one multiplier bit per clock) instead of an N×N array, which makes wide N practical. Transactions use valid/ready handshakes on both sides. It adds rounding, saturation, negative-zero suppression and a sticky overflow flag. It sits between fixed-point producers/consumers wherever area matters more than throughput.

---
 rtl/qmult_seq.sv | 132 +++++++++++++
 tb/tb_qmult_seq.sv | 386 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/qmult_seq.sv
// Sequential sign-magnitude Qm.n multiplier: one multiplier bit per clock,
// with optional rounding, saturation, negative-zero suppression and a sticky overflow flag.
module qmult_seq #(
    parameter int N     = 32,
    parameter int Q     = 15,
    parameter int ROUND = 0,
    parameter int SAT   = 1
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_valid,
    output logic         o_ready,
    input  logic [N-1:0] i_multiplicand,
    input  logic [N-1:0] i_multiplier,
    output logic         o_valid,
    input  logic         i_ready,
    output logic [N-1:0] o_result,
    output logic         o_ovr,
    output logic         o_ovr_sticky,
    input  logic         i_clr_sticky,
    output logic         o_busy
);

    localparam int PW = 2 * N - 2;
    localparam int CW = $clog2(N);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_FIN,
        S_DONE
    } state_t;

    state_t        r_state;
    logic [PW-1:0] r_mcand;
    logic [N-2:0]  r_mplier;
    logic [PW-1:0] r_acc;
    logic [CW-1:0] r_cnt;
    logic          r_sign;
    logic [N-1:0]  r_result;
    logic          r_ovr;
    logic          r_valid;
    logic          r_sticky;

    logic [N-2:0]  w_trunc;
    logic          w_rbit;
    logic [N-1:0]  w_sum;
    logic          w_hi_ovr;
    logic          w_ovr;
    logic [N-2:0]  w_mag;
    logic          w_sign;
    logic          w_unused_acc;

    // Post-processing of the exact product, consumed only in the FIN cycle.
    assign w_trunc      = r_acc[N-2+Q:Q];
    assign w_rbit       = (ROUND != 0) ? r_acc[Q-1] : 1'b0;
    assign w_sum        = {1'b0, w_trunc} + {{(N-1){1'b0}}, w_rbit};
    assign w_hi_ovr     = |r_acc[PW-1:N-1+Q];
    assign w_ovr        = w_hi_ovr | w_sum[N-1];
    assign w_mag        = (w_ovr && (SAT != 0)) ? {(N-1){1'b1}} : w_sum[N-2:0];
    assign w_sign       = r_sign & (|w_mag);
    assign w_unused_acc = ^r_acc;

    assign o_ready      = (r_state == S_IDLE);
    assign o_busy       = (r_state == S_CALC) || (r_state == S_FIN);
    assign o_valid      = r_valid;
    assign o_result     = r_result;
    assign o_ovr        = r_ovr;
    assign o_ovr_sticky = r_sticky;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of the others, independent of statement order.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state  <= S_IDLE;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_acc    <= '0;
            r_cnt    <= '0;
            r_sign   <= 1'b0;
            r_result <= '0;
            r_ovr    <= 1'b0;
            r_valid  <= 1'b0;
            r_sticky <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_valid) begin
                        r_mcand  <= {{(N-1){1'b0}}, i_multiplicand[N-2:0]};
                        r_mplier <= i_multiplier[N-2:0];
                        r_sign   <= i_multiplicand[N-1] ^ i_multiplier[N-1];
                        r_acc    <= '0;
                        r_cnt    <= '0;
                        r_state  <= S_CALC;
                    end
                end
                S_CALC: begin
                    if (r_mplier[0]) begin
                        r_acc <= r_acc + r_mcand;
                    end
                    r_mcand  <= r_mcand << 1;
                    r_mplier <= r_mplier >> 1;
                    r_cnt    <= r_cnt + CW'(1);
                    if (r_cnt == CW'(N - 2)) begin
                        r_state <= S_FIN;
                    end
                end
                S_FIN: begin
                    r_result <= {w_sign, w_mag};
                    r_ovr    <= w_ovr;
                    r_valid  <= 1'b1;
                    r_state  <= S_DONE;
                end
                S_DONE: begin
                    if (i_ready) begin
                        r_valid <= 1'b0;
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase

            // A new overflow outranks a clear arriving on the same edge.
            if ((r_state == S_FIN) && w_ovr) begin
                r_sticky <= 1'b1;
            end else if (i_clr_sticky) begin
                r_sticky <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_qmult_seq.sv
// Bench for qmult_seq: three instances (truncate/saturate, truncate/wrap, round/saturate)
// share stimulus and are compared against an arithmetic reference model.
module tb_qmult_seq;

    localparam int N = 32;
    localparam int Q = 15;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        valid = 1'b0;
    logic        ready_in = 1'b0;
    logic        clr = 1'b0;
    logic [31:0] mcand = '0;
    logic [31:0] mplier = '0;

    logic        rdy [3];
    logic        vld [3];
    logic        ovr [3];
    logic        stk [3];
    logic        busy[3];
    logic [31:0] res [3];

    int          n_checks = 0;
    int          n_fail = 0;
    bit          exp_sticky[3] = '{0, 0, 0};
    logic [31:0] cur_a, cur_b;

    always #5 clk = ~clk;

    qmult_seq #(.N(N), .Q(Q), .ROUND(0), .SAT(1)) u_dut0 (
        .i_clk(clk), .i_rst_n(rst_n), .i_valid(valid), .o_ready(rdy[0]),
        .i_multiplicand(mcand), .i_multiplier(mplier), .o_valid(vld[0]),
        .i_ready(ready_in), .o_result(res[0]), .o_ovr(ovr[0]),
        .o_ovr_sticky(stk[0]), .i_clr_sticky(clr), .o_busy(busy[0]));

    qmult_seq #(.N(N), .Q(Q), .ROUND(0), .SAT(0)) u_dut1 (
        .i_clk(clk), .i_rst_n(rst_n), .i_valid(valid), .o_ready(rdy[1]),
        .i_multiplicand(mcand), .i_multiplier(mplier), .o_valid(vld[1]),
        .i_ready(ready_in), .o_result(res[1]), .o_ovr(ovr[1]),
        .o_ovr_sticky(stk[1]), .i_clr_sticky(clr), .o_busy(busy[1]));

    qmult_seq #(.N(N), .Q(Q), .ROUND(1), .SAT(1)) u_dut2 (
        .i_clk(clk), .i_rst_n(rst_n), .i_valid(valid), .o_ready(rdy[2]),
        .i_multiplicand(mcand), .i_multiplier(mplier), .o_valid(vld[2]),
        .i_ready(ready_in), .o_result(res[2]), .o_ovr(ovr[2]),
        .o_ovr_sticky(stk[2]), .i_clr_sticky(clr), .o_busy(busy[2]));

    // Reference: exact product scaled by 2^-Q, optional half-up, then range handling.
    // Returns {ovr, sign, magnitude}. Instance 1 wraps, instance 2 rounds.
    function automatic logic [32:0] model(input logic [31:0] a, input logic [31:0] b, input int d);
        logic [63:0] p, s;
        logic [31:0] mag;
        logic        o, sign;
        p = 64'(a[30:0]) * 64'(b[30:0]);
        s = p >> Q;
        if (d == 2) s = s + ((p >> (Q - 1)) & 64'd1);
        o = (s >= 64'h8000_0000);
        if (o) mag = (d != 1) ? 32'h7FFF_FFFF : 32'(s % 64'h8000_0000);
        else   mag = s[31:0];
        sign = (a[31] ^ b[31]) && (mag != 32'd0);
        return {o, sign, mag[30:0]};
    endfunction

    task automatic start_txn(input logic [31:0] a, input logic [31:0] b);
        bit acc;
        acc = 1'b0;
        cur_a = a; cur_b = b;
        mcand = a; mplier = b; valid = 1'b1;
        for (int i = 0; i < 100 && !acc; i++) begin
            acc = rdy[0];
            @(posedge clk); #1;
        end
        valid = 1'b0;
        mcand = $urandom; mplier = $urandom;
        if (!acc) begin
            n_checks++; n_fail++;
            $display("FAIL accept_timeout: o_ready got 0, required 1");
        end
    endtask

    task automatic wait_result(output int lat, input bit clr_at_fin);
        logic [32:0] e;
        lat = 0;
        while (lat < 100 && vld[0] !== 1'b1) begin
            if (clr_at_fin && lat == N - 1) clr = 1'b1;
            @(posedge clk); #1;
            lat++;
            if (clr_at_fin) clr = 1'b0;
        end
        if (vld[0] !== 1'b1) begin
            n_checks++; n_fail++;
            $display("FAIL result_timeout: o_valid got %b, required 1", vld[0]);
        end
        for (int d = 0; d < 3; d++) begin
            e = model(cur_a, cur_b, d);
            if (e[32]) exp_sticky[d] = 1'b1;
        end
    endtask

    task automatic consume();
        ready_in = 1'b1;
        @(posedge clk); #1;
        ready_in = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        for (int d = 0; d < 3; d++) begin
            n_checks++;
            if ({rdy[d], vld[d], res[d], ovr[d], stk[d], busy[d]} !== {1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0}) begin
                n_fail++;
                $display("FAIL reset_state[%0d]: got rdy=%b vld=%b res=%h ovr=%b stk=%b busy=%b, required 1 0 00000000 0 0 0",
                         d, rdy[d], vld[d], res[d], ovr[d], stk[d], busy[d]);
            end
        end
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_basic();
        int lat;
        logic [32:0] e;
        start_txn(32'h0000C000, 32'h80010000);
        n_checks++;
        if (busy[0] !== 1'b1 || rdy[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_busy: got busy=%b rdy=%b, required 1 0", busy[0], rdy[0]);
        end
        wait_result(lat, 1'b0);
        n_checks++;
        if (lat != N) begin
            n_fail++;
            $display("FAIL basic_latency: got %0d, required %0d", lat, N);
        end
        n_checks++;
        if (res[0] !== 32'h80018000 || ovr[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_result: got %h ovr=%b, required 80018000 ovr=0", res[0], ovr[0]);
        end
        for (int d = 0; d < 3; d++) begin
            e = model(cur_a, cur_b, d);
            n_checks++;
            if (res[d] !== e[31:0] || ovr[d] !== e[32]) begin
                n_fail++;
                $display("FAIL basic_model[%0d]: got %h ovr=%b, required %h ovr=%b", d, res[d], ovr[d], e[31:0], e[32]);
            end
        end
        consume();
        n_checks++;
        if (rdy[0] !== 1'b1 || vld[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_idle: got rdy=%b vld=%b, required 1 0", rdy[0], vld[0]);
        end
    endtask

    task automatic test_overflow();
        int lat;
        start_txn(32'h00800000, 32'h00800000);
        wait_result(lat, 1'b0);
        n_checks++;
        if (res[0] !== 32'h7FFFFFFF || ovr[0] !== 1'b1 || stk[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL ovr_sat: got %h ovr=%b stk=%b, required 7fffffff 1 1", res[0], ovr[0], stk[0]);
        end
        n_checks++;
        if (res[1] !== 32'h00000000 || ovr[1] !== 1'b1) begin
            n_fail++;
            $display("FAIL ovr_wrap: got %h ovr=%b, required 00000000 1", res[1], ovr[1]);
        end
        consume();
    endtask

    task automatic test_rounding();
        int lat;
        logic [32:0] e;
        start_txn(32'h80000001, 32'h00004000);
        wait_result(lat, 1'b0);
        n_checks++;
        if (res[0] !== 32'h00000000) begin
            n_fail++;
            $display("FAIL round_trunc_negzero: got %h, required 00000000", res[0]);
        end
        n_checks++;
        if (res[2] !== 32'h80000001 || ovr[2] !== 1'b0) begin
            n_fail++;
            $display("FAIL round_halfup: got %h ovr=%b, required 80000001 0", res[2], ovr[2]);
        end
        consume();
        start_txn(32'h7FFFFFFF, 32'h7FFFFFFF);
        wait_result(lat, 1'b0);
        for (int d = 0; d < 3; d++) begin
            e = model(cur_a, cur_b, d);
            n_checks++;
            if (res[d] !== e[31:0] || ovr[d] !== 1'b1) begin
                n_fail++;
                $display("FAIL round_max[%0d]: got %h ovr=%b, required %h ovr=1", d, res[d], ovr[d], e[31:0]);
            end
        end
        consume();
    endtask

    task automatic test_sticky();
        int lat;
        clr = 1'b1;
        @(posedge clk); #1;
        clr = 1'b0;
        exp_sticky = '{0, 0, 0};
        for (int d = 0; d < 3; d++) begin
            n_checks++;
            if (stk[d] !== 1'b0) begin
                n_fail++;
                $display("FAIL sticky_clear[%0d]: got %b, required 0", d, stk[d]);
            end
        end
        start_txn(32'h0000C000, 32'h80010000);
        wait_result(lat, 1'b0);
        consume();
        for (int d = 0; d < 3; d++) begin
            n_checks++;
            if (stk[d] !== 1'b0) begin
                n_fail++;
                $display("FAIL sticky_no_ovr[%0d]: got %b, required 0", d, stk[d]);
            end
        end
        start_txn(32'h00800000, 32'h00800000);
        wait_result(lat, 1'b0);
        consume();
        start_txn(32'h00400000, 32'h81000000);
        wait_result(lat, 1'b1);
        for (int d = 0; d < 3; d++) begin
            n_checks++;
            if (stk[d] !== exp_sticky[d] || stk[d] !== 1'b1) begin
                n_fail++;
                $display("FAIL sticky_set_wins[%0d]: got %b, required 1", d, stk[d]);
            end
        end
        consume();
    endtask

    task automatic test_backpressure();
        int lat;
        logic [32:0] e;
        start_txn(32'h80123456, 32'h00009876);
        wait_result(lat, 1'b0);
        e = model(cur_a, cur_b, 0);
        for (int c = 0; c < 10; c++) begin
            n_checks++;
            if (vld[0] !== 1'b1 || res[0] !== e[31:0] || ovr[0] !== e[32] || rdy[0] !== 1'b0) begin
                n_fail++;
                $display("FAIL hold_cycle%0d: got vld=%b res=%h ovr=%b rdy=%b, required 1 %h %b 0",
                         c, vld[0], res[0], ovr[0], rdy[0], e[31:0], e[32]);
            end
            @(posedge clk); #1;
        end
        consume();
        n_checks++;
        if (vld[0] !== 1'b0 || rdy[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL release_idle: got vld=%b rdy=%b, required 0 1", vld[0], rdy[0]);
        end
    endtask

    task automatic test_back_to_back();
        int cyc, r1, r2, nr;
        bit prev;
        logic [32:0] e;
        cur_a = 32'h00012345; cur_b = 32'h80003000;
        mcand = cur_a; mplier = cur_b;
        valid = 1'b1; ready_in = 1'b1;
        cyc = 0; nr = 0; r1 = 0; r2 = 0; prev = 1'b0;
        while (cyc < 200 && nr < 2) begin
            @(posedge clk); #1;
            cyc++;
            if (vld[0] === 1'b1 && !prev) begin
                nr++;
                if (nr == 1) r1 = cyc; else r2 = cyc;
                e = model(cur_a, cur_b, 0);
                n_checks++;
                if (res[0] !== e[31:0]) begin
                    n_fail++;
                    $display("FAIL b2b_result%0d: got %h, required %h", nr, res[0], e[31:0]);
                end
            end
            prev = (vld[0] === 1'b1);
        end
        valid = 1'b0;
        @(posedge clk); #1;
        ready_in = 1'b0;
        n_checks++;
        if (nr != 2 || r2 - r1 != N + 2) begin
            n_fail++;
            $display("FAIL b2b_spacing: got %0d results spaced %0d, required 2 spaced %0d", nr, r2 - r1, N + 2);
        end
    endtask

    task automatic test_reset_mid_op();
        int lat;
        logic [32:0] e;
        start_txn(32'h00800000, 32'h00800000);
        repeat (10) @(posedge clk);
        #1;
        n_checks++;
        if (busy[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_busy: got %b, required 1", busy[0]);
        end
        rst_n = 1'b0;
        #1;
        exp_sticky = '{0, 0, 0};
        for (int d = 0; d < 3; d++) begin
            n_checks++;
            if ({vld[d], rdy[d], busy[d], res[d], ovr[d], stk[d]} !== {1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0}) begin
                n_fail++;
                $display("FAIL mid_reset[%0d]: got vld=%b rdy=%b busy=%b res=%h ovr=%b stk=%b, required 0 1 0 00000000 0 0",
                         d, vld[d], rdy[d], busy[d], res[d], ovr[d], stk[d]);
            end
        end
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        start_txn(32'h00028000, 32'h0000A000);
        wait_result(lat, 1'b0);
        for (int d = 0; d < 3; d++) begin
            e = model(cur_a, cur_b, d);
            n_checks++;
            if (res[d] !== e[31:0] || ovr[d] !== e[32] || lat != N) begin
                n_fail++;
                $display("FAIL post_reset[%0d]: got %h ovr=%b lat=%0d, required %h ovr=%b lat=%0d",
                         d, res[d], ovr[d], lat, e[31:0], e[32], N);
            end
        end
        consume();
    endtask

    task automatic test_random();
        int lat;
        logic [31:0] a, b;
        logic [32:0] e;
        for (int t = 0; t < 40; t++) begin
            a = $urandom >> $urandom_range(0, 31);
            a[31] = 1'($urandom_range(0, 1));
            b = $urandom >> $urandom_range(0, 31);
            b[31] = 1'($urandom_range(0, 1));
            start_txn(a, b);
            wait_result(lat, 1'b0);
            for (int d = 0; d < 3; d++) begin
                e = model(a, b, d);
                n_checks++;
                if (res[d] !== e[31:0] || ovr[d] !== e[32] || stk[d] !== exp_sticky[d]) begin
                    n_fail++;
                    $display("FAIL random%0d[%0d]: a=%h b=%h got %h ovr=%b stk=%b, required %h ovr=%b stk=%b",
                             t, d, a, b, res[d], ovr[d], stk[d], e[31:0], e[32], exp_sticky[d]);
                end
            end
            consume();
            if ($urandom_range(0, 3) == 0) begin
                clr = 1'b1;
                @(posedge clk); #1;
                clr = 1'b0;
                exp_sticky = '{0, 0, 0};
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_overflow();
        test_rounding();
        test_sticky();
        test_backpressure();
        test_back_to_back();
        test_reset_mid_op();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog expired");
    end

endmodule
